// File: rtl/axi_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter_if
//
// Read-only AXI3 bus between the IF-stage read arbiter and the external
// interconnect. Only the AR and R channels exist, because the instruction
// side never writes.
//
// Signals:
//   AR channel : arid[3:0], araddr[ADDR_W-1:0], arlen[3:0], arsize[2:0],
//                arburst[1:0], arlock[1:0], arcache[3:0], arprot[2:0],
//                arvalid, arready
//   R channel  : rid[3:0], rdata[DATA_W-1:0], rresp[1:0], rlast, rvalid,
//                rready
//
// Modports:
//   master : the arbiter side (drives AR and rready)
//   slave  : the interconnect side (drives arready and R)
// ---------------------------------------------------------------------------
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    output arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
    input  arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares one AXI3 read master among the three instruction-side requesters:
//   0 = icache refill, 1 = uncached fetch, 2 = icache prefetch buffer.
// Exactly one read is in flight at a time. The grant is fixed priority
// (0 > 1 > 2), except that prefetch is forced through once it has been
// passed over STARVE_LIMIT times in a row. R beats are steered back to the
// granted requester using the latched grant, never the returned rid.
//
// Ports:
//   aclk, aresetn    : clock, asynchronous active-low reset
//   req_arvalid[3]   : per-requester read request
//   req_araddr       : 3 x ADDR_W addresses, slice i = requester i
//   req_arlen        : 3 x 4 burst length minus one
//   req_arsize       : 3 x 3 beat size
//   req_arready[3]   : address accepted (only the granted bit can be set)
//   req_rvalid[3]    : read beat valid (only the granted bit can be set)
//   req_rready[3]    : per-requester beat accept
//   req_rdata/rresp/rlast : shared read beat payload
//   axi              : AXI3 read master port (AR + R channels)
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [2:0]          req_arvalid,
  input  logic [3*ADDR_W-1:0] req_araddr,
  input  logic [3*4-1:0]      req_arlen,
  input  logic [3*3-1:0]      req_arsize,
  output logic [2:0]          req_arready,
  output logic [2:0]          req_rvalid,
  input  logic [2:0]          req_rready,
  output logic [DATA_W-1:0]   req_rdata,
  output logic [1:0]          req_rresp,
  output logic                req_rlast,
  axi_rd_arbiter_if.master    axi
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [1:0]        g, g_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
  logic [3:0]        lat_len, lat_len_nxt;
  logic [2:0]        lat_size, lat_size_nxt;

  logic [1:0]        pick;
  logic              starved;
  logic [2:0]        g_onehot;

  // rid is deliberately ignored: routing always follows the latched grant.
  logic              unused_rid;
  assign unused_rid = ^axi.rid;

  // Candidate grant for the next IDLE cycle. The starvation compare uses
  // the counter value before this grant updates it.
  always_comb begin
    starved = (starve_cnt == CNT_W'(STARVE_LIMIT)) && req_arvalid[2];
    if (starved) begin
      pick = 2'd2;
    end else if (req_arvalid[0]) begin
      pick = 2'd0;
    end else if (req_arvalid[1]) begin
      pick = 2'd1;
    end else begin
      pick = 2'd2;
    end
  end

  assign g_onehot = 3'b001 << g;

  // State, grant, starvation counter and latched AR fields.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      g          <= 2'd0;
      starve_cnt <= '0;
      lat_addr   <= '0;
      lat_len    <= '0;
      lat_size   <= '0;
    end else begin
      state      <= state_nxt;
      g          <= g_nxt;
      starve_cnt <= starve_cnt_nxt;
      lat_addr   <= lat_addr_nxt;
      lat_len    <= lat_len_nxt;
      lat_size   <= lat_size_nxt;
    end
  end

  // Next-state and handshake steering. arvalid and rready come straight
  // from the state register, so an asynchronous reset drops them at once.
  always_comb begin
    state_nxt      = state;
    g_nxt          = g;
    starve_cnt_nxt = starve_cnt;
    lat_addr_nxt   = lat_addr;
    lat_len_nxt    = lat_len;
    lat_size_nxt   = lat_size;
    axi.arvalid    = 1'b0;
    axi.rready     = 1'b0;
    req_arready    = 3'b000;
    req_rvalid     = 3'b000;

    case (state)
      IDLE: begin
        if (|req_arvalid) begin
          state_nxt    = ADDR;
          g_nxt        = pick;
          lat_addr_nxt = req_araddr[int'(pick)*ADDR_W +: ADDR_W];
          lat_len_nxt  = req_arlen[int'(pick)*4 +: 4];
          lat_size_nxt = req_arsize[int'(pick)*3 +: 3];
          // Prefetch only counts as starved while it is actually asking.
          if (pick == 2'd2) begin
            starve_cnt_nxt = '0;
          end else if (req_arvalid[2] && (starve_cnt != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
          end
        end
      end

      ADDR: begin
        axi.arvalid = 1'b1;
        req_arready = g_onehot & {3{axi.arready}};
        if (axi.arready) begin
          state_nxt = DATA;
        end
      end

      DATA: begin
        req_rvalid = g_onehot & {3{axi.rvalid}};
        axi.rready = |(g_onehot & req_rready);
        if (axi.rvalid && axi.rready && axi.rlast) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign axi.arid    = {2'b00, g};
  assign axi.araddr  = lat_addr;
  assign axi.arlen   = lat_len;
  assign axi.arsize  = lat_size;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'h0;
  assign axi.arprot  = 3'h0;

  assign req_rdata   = axi.rdata;
  assign req_rresp   = axi.rresp;
  assign req_rlast   = axi.rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Scoreboard bench for axi_rd_arbiter. Stimulus queues requests per
// requester and pushes the expected AR transactions and R beats in the
// order the arbiter should grant them. A requester model, a slave model and
// a monitor run as independent processes; the monitor pops expectations on
// every AR and R handshake and checks steering every cycle.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [3:0]        len;
    logic [2:0]        size;
  } req_t;

  typedef struct {
    logic [3:0]        id;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        len;
    logic [2:0]        size;
  } exp_ar_t;

  typedef struct {
    logic [1:0]        idx;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } exp_r_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } beat_t;

  logic                aclk = 1'b0;
  logic                aresetn = 1'b0;
  logic [2:0]          req_arvalid;
  logic [3*ADDR_W-1:0] req_araddr;
  logic [11:0]         req_arlen;
  logic [8:0]          req_arsize;
  logic [2:0]          req_arready;
  logic [2:0]          req_rvalid;
  logic [2:0]          req_rready;
  logic [DATA_W-1:0]   req_rdata;
  logic [1:0]          req_rresp;
  logic                req_rlast;

  req_t    rq0[$];
  req_t    rq1[$];
  req_t    rq2[$];
  exp_ar_t exp_ar[$];
  exp_r_t  exp_r[$];
  beat_t   sl_beats[$];
  logic [3:0] sl_ids[$];

  int checks = 0;
  int errors = 0;
  int ar_delay = 0;
  bit rr_toggle = 1'b0;
  int r_hs_total = 0;

  axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_rd_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(8)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .req_arvalid(req_arvalid),
    .req_araddr (req_araddr),
    .req_arlen  (req_arlen),
    .req_arsize (req_arsize),
    .req_arready(req_arready),
    .req_rvalid (req_rvalid),
    .req_rready (req_rready),
    .req_rdata  (req_rdata),
    .req_rresp  (req_rresp),
    .req_rlast  (req_rlast),
    .axi        (bus.master)
  );

  always #5 aclk = ~aclk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Queue a request at requester idx; the requester model presents it.
  task automatic applyStimulus(input int idx, input logic [ADDR_W-1:0] addr,
                               input logic [3:0] len, input logic [2:0] size);
    req_t r;
    r.addr = addr;
    r.len  = len;
    r.size = size;
    case (idx)
      0:       rq0.push_back(r);
      1:       rq1.push_back(r);
      default: rq2.push_back(r);
    endcase
  endtask

  // Expected grant, in grant order: AR fields, beats, and the slave's data.
  task automatic expectTxn(input int idx, input logic [ADDR_W-1:0] addr,
                           input logic [3:0] len, input logic [2:0] size,
                           input logic [DATA_W-1:0] base);
    exp_ar_t ea;
    exp_r_t  er;
    beat_t   b;
    ea.id   = 4'(idx);
    ea.addr = addr;
    ea.len  = len;
    ea.size = size;
    exp_ar.push_back(ea);
    for (int i = 0; i <= int'(len); i++) begin
      er.idx  = 2'(idx);
      er.data = base + DATA_W'(i);
      er.resp = 2'(i);
      er.last = (i == int'(len));
      exp_r.push_back(er);
      b.data = er.data;
      b.resp = er.resp;
      b.last = er.last;
      sl_beats.push_back(b);
    end
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while ((exp_ar.size() > 0 || exp_r.size() > 0) && n < budget) begin
      @(negedge aclk);
      n++;
    end
    checkOutput("drain_timeout", 64'(exp_ar.size() + exp_r.size()), 64'(0));
    repeat (3) @(negedge aclk);
  endtask

  // Requester model: hold each request until its req_arready handshake.
  initial begin : requesters
    logic [2:0] hs;
    bit phase;
    phase = 1'b0;
    req_arvalid = 3'b000;
    req_araddr  = '0;
    req_arlen   = '0;
    req_arsize  = '0;
    req_rready  = 3'b111;
    forever begin
      @(negedge aclk);
      hs = req_arvalid & req_arready;
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        rq0.delete();
        rq1.delete();
        rq2.delete();
      end else begin
        if (hs[0] && rq0.size() > 0) rq0.delete(0);
        if (hs[1] && rq1.size() > 0) rq1.delete(0);
        if (hs[2] && rq2.size() > 0) rq2.delete(0);
      end
      req_arvalid[0] = (rq0.size() > 0);
      req_arvalid[1] = (rq1.size() > 0);
      req_arvalid[2] = (rq2.size() > 0);
      if (rq0.size() > 0) begin
        req_araddr[0 +: ADDR_W] = rq0[0].addr;
        req_arlen[0 +: 4]       = rq0[0].len;
        req_arsize[0 +: 3]      = rq0[0].size;
      end
      if (rq1.size() > 0) begin
        req_araddr[ADDR_W +: ADDR_W] = rq1[0].addr;
        req_arlen[4 +: 4]            = rq1[0].len;
        req_arsize[3 +: 3]           = rq1[0].size;
      end
      if (rq2.size() > 0) begin
        req_araddr[2*ADDR_W +: ADDR_W] = rq2[0].addr;
        req_arlen[8 +: 4]              = rq2[0].len;
        req_arsize[6 +: 3]             = rq2[0].size;
      end
      phase = ~phase;
      req_rready = rr_toggle ? {3{phase}} : 3'b111;
    end
  end

  // Slave model: arready after ar_delay wait cycles, beats in order.
  initial begin : slave
    bit ar_hs;
    bit r_hs;
    logic [3:0] hs_id;
    int ar_wait;
    ar_wait = 0;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rid     = 4'h0;
    bus.rdata   = '0;
    bus.rresp   = 2'b00;
    bus.rlast   = 1'b0;
    forever begin
      @(negedge aclk);
      ar_hs = bus.arvalid && bus.arready;
      hs_id = bus.arid;
      r_hs  = bus.rvalid && bus.rready;
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        sl_ids.delete();
        sl_beats.delete();
      end else begin
        if (ar_hs) sl_ids.push_back(hs_id);
        if (r_hs && sl_beats.size() > 0) begin
          if (sl_beats[0].last && sl_ids.size() > 0) sl_ids.delete(0);
          sl_beats.delete(0);
        end
      end
      if (aresetn && bus.arvalid) begin
        bus.arready = (ar_wait >= ar_delay);
        ar_wait++;
      end else begin
        bus.arready = 1'b0;
        ar_wait = 0;
      end
      if (aresetn && sl_ids.size() > 0 && sl_beats.size() > 0) begin
        bus.rvalid = 1'b1;
        bus.rid    = sl_ids[0];
        bus.rdata  = sl_beats[0].data;
        bus.rresp  = sl_beats[0].resp;
        bus.rlast  = sl_beats[0].last;
      end else begin
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
      end
    end
  end

  // Monitor: pops expectations on handshakes, checks steering every cycle.
  initial begin : monitor
    logic prev_arvalid;
    logic prev_arready;
    logic [ADDR_W-1:0] prev_araddr;
    logic [3:0] prev_arlen;
    bit in_data;
    bit data_next;
    bit last_seen;
    int gap;
    logic [1:0] owner;
    logic [2:0] exp_rv;
    logic [2:0] exp_ard;
    exp_ar_t ea;
    exp_r_t er;
    prev_arvalid = 1'b0;
    prev_arready = 1'b0;
    prev_araddr  = '0;
    prev_arlen   = '0;
    in_data = 1'b0;
    data_next = 1'b0;
    last_seen = 1'b0;
    gap = 0;
    owner = 2'd0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        exp_ar.delete();
        exp_r.delete();
        in_data = 1'b0;
        data_next = 1'b0;
        last_seen = 1'b0;
        prev_arvalid = 1'b0;
        prev_arready = 1'b0;
        continue;
      end
      if (data_next) begin
        in_data = 1'b1;
        data_next = 1'b0;
      end

      if (prev_arvalid && !prev_arready) begin
        checkOutput("arvalid_hold", 64'(bus.arvalid), 64'(1));
        checkOutput("araddr_stable", 64'(bus.araddr), 64'(prev_araddr));
        checkOutput("arlen_stable", 64'(bus.arlen), 64'(prev_arlen));
      end

      if (bus.arvalid && !prev_arvalid && last_seen) begin
        checkOutput("idle_ar_gap", 64'(gap), 64'(1));
        last_seen = 1'b0;
      end else if (last_seen && !bus.arvalid) begin
        gap++;
      end

      checkOutput("ar_r_overlap", 64'(bus.arvalid && (|req_rvalid)), 64'(0));
      exp_rv = in_data ? ({2'b00, bus.rvalid} << owner) : 3'b000;
      checkOutput("req_rvalid_route", 64'(req_rvalid), 64'(exp_rv));
      checkOutput("rready_mirror", 64'(bus.rready), 64'(in_data ? req_rready[owner] : 1'b0));
      if (exp_ar.size() > 0) begin
        exp_ard = bus.arvalid ? ({2'b00, bus.arready} << exp_ar[0].id[1:0]) : 3'b000;
        checkOutput("req_arready_route", 64'(req_arready), 64'(exp_ard));
      end

      if (bus.arvalid && bus.arready) begin
        if (exp_ar.size() == 0) begin
          checkOutput("ar_unexpected", 64'(bus.arid), 64'hFFFF);
        end else begin
          ea = exp_ar.pop_front();
          checkOutput("arid", 64'(bus.arid), 64'(ea.id));
          checkOutput("araddr", 64'(bus.araddr), 64'(ea.addr));
          checkOutput("arlen", 64'(bus.arlen), 64'(ea.len));
          checkOutput("arsize", 64'(bus.arsize), 64'(ea.size));
          checkOutput("ar_fixed_fields",
                      64'({bus.arburst, bus.arlock, bus.arcache, bus.arprot}),
                      64'({2'b01, 2'b00, 4'h0, 3'h0}));
          owner = ea.id[1:0];
          data_next = 1'b1;
        end
      end

      if (bus.rvalid && bus.rready) begin
        r_hs_total++;
        if (exp_r.size() == 0) begin
          checkOutput("r_unexpected", 64'(req_rdata), 64'hFFFF_FFFF_FFFF);
        end else begin
          er = exp_r.pop_front();
          checkOutput("r_owner", 64'(req_rvalid), 64'(3'b001 << er.idx));
          checkOutput("r_data", 64'(req_rdata), 64'(er.data));
          checkOutput("r_resp", 64'(req_rresp), 64'(er.resp));
          checkOutput("r_last", 64'(req_rlast), 64'(er.last));
          if (er.last) begin
            in_data = 1'b0;
            last_seen = (exp_ar.size() > 0);
            gap = 0;
          end
        end
      end

      prev_arvalid = bus.arvalid;
      prev_arready = bus.arready;
      prev_araddr  = bus.araddr;
      prev_arlen   = bus.arlen;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int start;
    int n;
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    checkOutput("rst_arvalid", 64'(bus.arvalid), 64'(0));
    checkOutput("rst_rready", 64'(bus.rready), 64'(0));
    checkOutput("rst_req_arready", 64'(req_arready), 64'(0));
    checkOutput("rst_req_rvalid", 64'(req_rvalid), 64'(0));
    checkOutput("rst_araddr", 64'(bus.araddr), 64'(0));
    checkOutput("rst_arlen", 64'(bus.arlen), 64'(0));
    checkOutput("rst_arsize", 64'(bus.arsize), 64'(0));
    checkOutput("rst_arid", 64'(bus.arid), 64'(0));
    @(posedge aclk);
    #2;
    aresetn = 1'b1;

    $display("[TB] single uncached read");
    @(negedge aclk);
    expectTxn(1, 32'h1FC0_0000, 4'd0, 3'd2, 32'h2400_0001);
    applyStimulus(1, 32'h1FC0_0000, 4'd0, 3'd2);
    @(negedge aclk);
    checkOutput("lat_arvalid_before", 64'(bus.arvalid), 64'(0));
    @(negedge aclk);
    checkOutput("lat_arvalid_after", 64'(bus.arvalid), 64'(1));
    waitDone(50);
    checkOutput("single_back_idle", 64'({bus.arvalid, bus.rready}), 64'(0));

    $display("[TB] simultaneous requests");
    @(negedge aclk);
    expectTxn(0, 32'h0000_1000, 4'd7, 3'd2, 32'hA000_0000);
    expectTxn(1, 32'h0000_2000, 4'd7, 3'd2, 32'hB000_0000);
    expectTxn(2, 32'h0000_3000, 4'd7, 3'd2, 32'hC000_0000);
    applyStimulus(0, 32'h0000_1000, 4'd7, 3'd2);
    applyStimulus(1, 32'h0000_2000, 4'd7, 3'd2);
    applyStimulus(2, 32'h0000_3000, 4'd7, 3'd2);
    waitDone(200);

    $display("[TB] prefetch starvation");
    @(negedge aclk);
    for (int i = 0; i < 8; i++) begin
      expectTxn(0, 32'h0000_4000 + 32'(i * 16), 4'd0, 3'd2, 32'hD000_0000 + 32'(i * 256));
    end
    expectTxn(2, 32'h0000_5000, 4'd0, 3'd2, 32'hE000_0000);
    for (int i = 8; i < 10; i++) begin
      expectTxn(0, 32'h0000_4000 + 32'(i * 16), 4'd0, 3'd2, 32'hD000_0000 + 32'(i * 256));
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 32'h0000_4000 + 32'(i * 16), 4'd0, 3'd2);
    end
    applyStimulus(2, 32'h0000_5000, 4'd0, 3'd2);
    waitDone(300);
    checkOutput("starve_cnt_cleared", 64'(dut.starve_cnt), 64'(0));

    $display("[TB] R backpressure with AR wait states");
    @(negedge aclk);
    ar_delay  = 2;
    rr_toggle = 1'b1;
    expectTxn(0, 32'h0000_6000, 4'd7, 3'd2, 32'h0000_0000);
    applyStimulus(0, 32'h0000_6000, 4'd7, 3'd2);
    waitDone(200);
    ar_delay  = 0;
    rr_toggle = 1'b0;

    $display("[TB] reset mid-burst");
    @(negedge aclk);
    expectTxn(0, 32'h0000_7000, 4'd7, 3'd2, 32'hF000_0000);
    applyStimulus(0, 32'h0000_7000, 4'd7, 3'd2);
    start = r_hs_total;
    n = 0;
    do begin
      @(negedge aclk);
      #1;
      n++;
    end while (r_hs_total < start + 4 && n < 100);
    checkOutput("reset_wait_beats", 64'(r_hs_total - start), 64'(4));
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("midrst_arvalid", 64'(bus.arvalid), 64'(0));
    checkOutput("midrst_rready", 64'(bus.rready), 64'(0));
    checkOutput("midrst_req_rvalid", 64'(req_rvalid), 64'(0));
    checkOutput("midrst_req_arready", 64'(req_arready), 64'(0));
    repeat (3) @(negedge aclk);
    @(posedge aclk);
    #2;
    aresetn = 1'b1;
    @(negedge aclk);
    expectTxn(1, 32'h0000_8000, 4'd3, 3'd2, 32'h1234_0000);
    applyStimulus(1, 32'h0000_8000, 4'd3, 3'd2);
    waitDone(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Shares one AXI3 read-only master port among the three instruction-side read requesters of the IF stage: icache refill (index 0), uncached instruction fetch (index 1), and the icache prefetch buffer (index 2). It sits between those requesters and the external AXI interconnect. It keeps exactly one read transaction in flight, grants by fixed priority with a prefetch anti-starvation override, and routes the R channel back to the granted requester.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STARVE_LIMIT`, default 8: number of consecutive higher-priority grants made while prefetch waits; when reached, prefetch is forced to win.
- `aclk` in 1: clock. Only one clock is used.
- `aresetn` in 1: reset, asynchronous and active-low.
- `req_arvalid` in 3: per-requester read request.
- `req_araddr` in 3*ADDR_W: per-requester address. Slice i belongs to requester i.
- `req_arlen` in 3*4: per-requester burst length minus 1.
- `req_arsize` in 3*3: per-requester beat size.
- `req_arready` out 3: per-requester address accepted.
- `req_rvalid` out 3: per-requester read beat valid.
- `req_rready` in 3: per-requester beat accept.
- `req_rdata` out DATA_W: read data, shared by all requesters.
- `req_rresp` out 2: read response, shared.
- `req_rlast` out 1: last beat, shared.
- `arid`, `araddr`, `arlen`, `arsize`, `arburst`, `arlock`, `arcache`, `arprot`, `arvalid` out: AXI AR channel, with widths 4/ADDR_W/4/3/2/2/4/3/1.
- `arready` in 1: AXI AR ready.
- `rid`, `rdata`, `rresp`, `rlast`, `rvalid` in: AXI R channel, with widths 4/DATA_W/2/1/1.
- `rready` out 1: AXI R ready.

## Operation
- The state machine has three states: IDLE, ADDR, DATA.
- **IDLE:** if any `req_arvalid` is set, pick grant `g`, latch that requester's addr/len/size, and go to ADDR. Otherwise stay in IDLE.
- **Priority:**
  - By default, 0 beats 1 beats 2.
  - If `starve_cnt == STARVE_LIMIT` and `req_arvalid[2]` is set, grant 2.
- **Starvation counter:**
  - `starve_cnt` increments, saturating, on each grant to 0 or 1 made while `req_arvalid[2]` is high.
  - It clears on a grant to 2.
- **ADDR:**
  - Drive `arvalid` = 1 from the latched registers.
  - `arid` = {2'b00, g[1:0]}.
  - `arburst` = 2'b01 (INCR); `arlock`, `arcache`, `arprot` = 0.
  - `req_arready[g]` = `arready`, combinationally; all other bits are 0.
  - On `arvalid && arready`, go to DATA.
- **DATA:**
  - `req_rvalid[g]` = `rvalid` and `rready` = `req_rready[g]`.
  - `req_rdata`/`req_rresp`/`req_rlast` pass `rdata`/`rresp`/`rlast` through unchanged.
  - On `rvalid && rready && rlast`, go to IDLE.
- `rid` is not checked. Data is routed by the latched `g`.
- Requesters must hold `req_arvalid` and its fields stable until `req_arready`, per the AXI rule. The latched values are authoritative once ADDR is entered.
- Non-granted requesters see `req_arready` = 0 and `req_rvalid` = 0 at all times.

## Timing
- **Reset values:** state IDLE; `g` = 0; `starve_cnt` = 0; `arvalid` = 0; `rready` = 0; `req_arready` = 0; `req_rvalid` = 0; `araddr`/`arlen`/`arsize`/`arid` = 0.
- Reset asserted mid-transaction drops `arvalid`/`rready` immediately (asynchronously) and abandons the burst.
- **Latency:**
  - A request sampled in IDLE at edge N gives `arvalid` = 1 from cycle N+1.
  - The AR handshake at edge M enables the R path from cycle M+1.
  - `arvalid` is never asserted in the same cycle as a DATA-state beat.
- **Back-to-back:**
  - The `rlast` handshake at edge L returns to IDLE in cycle L+1.
  - The next grant is sampled at edge L+1 and the next `arvalid` rises in cycle L+2, giving exactly one idle AR cycle between transactions.
- `arvalid` stays high, with stable fields, until `arready`. Any number of wait cycles is legal.
- R backpressure: when `req_rready[g]` = 0, `rready` = 0 and the beat is held by the slave. The arbiter does no buffering.
- A request arriving during ADDR/DATA waits. Grant is re-evaluated only in IDLE.
- The `starve_cnt` compare uses the pre-increment value. It saturates at `STARVE_LIMIT` and never wraps.

## Test plan
- **Single uncached read:** `req_arvalid` = 3'b010, addr 0x1FC0_0000, len 0. Expect `arid` = 1, `arlen` = 0, `arvalid` the cycle after the request. Send one R beat 0x2400_0001 with `rlast`. Expect `req_rvalid[1]` for 1 cycle, `req_rdata` = 0x2400_0001, then IDLE.
- **Simultaneous requests:** `req_arvalid` = 3'b111. Expect grant order 0, 1, 2, each an 8-beat burst (len 7) with `arid` 0, 1, 2. Expect exactly one idle AR cycle between the three bursts.
- **Prefetch starvation:** hold `req_arvalid[2]` high while re-requesting 0 continuously. Expect the 9th grant to go to 2 (after 8 grants to 0), `starve_cnt` to return to 0, and the next grant to go back to 0.
- **Backpressure:** during an 8-beat burst, toggle `req_rready[0]` 1/0 each cycle. Expect `rready` to mirror it, all 8 beats 0..7 delivered in order, and no other `req_rvalid` bit ever set.
- **Reset mid-burst:** drop `aresetn` after beat 3 of 8. Expect `arvalid`/`rready`/`req_rvalid` = 0 immediately and state IDLE. After release, a new request to 1 completes normally.
